instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 115 +++++++++++
 tb/tb_instr_fetch.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one RAM read at a time, holds the returned
// word in ir until the controller consumes it, and supports branch redirect and halt.
module instr_fetch #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] start_pc,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd_en,
    input  logic [31:0]       ram_rdata,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt,
    input  logic              ir_ready,
    output logic              ir_valid,
    output logic [31:0]       ir,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next,
    output logic              halted
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [2:0] {
        START  = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        HOLD   = 3'd3,
        HALTED = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  fp, fp_nxt;
    logic [ADDR_W-1:0]  pc_q, pc_nxt;
    logic [31:0]        ir_q, ir_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= START;
            fp    <= '0;
            pc_q  <= '0;
            ir_q  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            fp    <= fp_nxt;
            pc_q  <= pc_nxt;
            ir_q  <= ir_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_nxt = state;
        fp_nxt    = fp;
        pc_nxt    = pc_q;
        ir_nxt    = ir_q;
        cnt_nxt   = cnt;

        case (state)
            START: begin
                fp_nxt    = start_pc;
                state_nxt = ISSUE;
            end
            ISSUE: begin
                cnt_nxt   = CNT_W'(RD_LAT - 1);
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt == '0) begin
                    ir_nxt    = ram_rdata;
                    pc_nxt    = fp;
                    fp_nxt    = fp + ADDR_W'(1);
                    state_nxt = HOLD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            HOLD: begin
                if (ir_ready) begin
                    state_nxt = halt ? HALTED : ISSUE;
                end
            end
            HALTED: begin
                state_nxt = HALTED;
            end
            default: begin
                state_nxt = START;
            end
        endcase

        // Redirect overrides everything outside HALTED; an in-flight read is dropped
        if (branch_en && (state != HALTED)) begin
            fp_nxt    = branch_target;
            pc_nxt    = pc_q;
            ir_nxt    = ir_q;
            cnt_nxt   = cnt;
            state_nxt = ISSUE;
        end
    end

    assign ram_addr  = fp;
    assign ram_rd_en = (state == ISSUE);
    assign ir_valid  = (state == HOLD);
    assign halted    = (state == HALTED);
    assign ir        = ir_q;
    assign pc        = pc_q;
    assign pc_next   = pc_q + ADDR_W'(1);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch with a fixed-latency instruction RAM model.
module tb_instr_fetch;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] start_pc = '0;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rd_en;
    logic [31:0]       ram_rdata;
    logic              branch_en = 1'b0;
    logic [ADDR_W-1:0] branch_target = '0;
    logic              halt = 1'b0;
    logic              ir_ready = 1'b0;
    logic              ir_valid;
    logic [31:0]       ir;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic              halted;

    int checks = 0;
    int failures = 0;

    instr_fetch #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .start_pc(start_pc),
        .ram_addr(ram_addr), .ram_rd_en(ram_rd_en), .ram_rdata(ram_rdata),
        .branch_en(branch_en), .branch_target(branch_target),
        .halt(halt), .ir_ready(ir_ready),
        .ir_valid(ir_valid), .ir(ir), .pc(pc), .pc_next(pc_next), .halted(halted)
    );

    always #5 clk = ~clk;

    // RAM: word i holds 0xC0DE0000+i, except address 0x010
    logic [31:0]       mem [DEPTH];
    logic [RD_LAT-1:0] pv;
    logic [ADDR_W-1:0] pa [RD_LAT];

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = 32'hC0DE_0000 + 32'(i);
        mem[11'h010] = 32'hE3A0_1005;
        pv = '0;
        for (int i = 0; i < int'(RD_LAT); i++) pa[i] = '0;
    end

    always @(posedge clk) begin
        pv[0] <= ram_rd_en;
        pa[0] <= ram_addr;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
        end
    end

    assign ram_rdata = pv[RD_LAT-1] ? mem[pa[RD_LAT-1]] : 32'hBAD0_BAD0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until ir_valid; n = cycles taken, or -1 on timeout
    task automatic wait_hold(input int max, output int n);
        n = 0;
        while (!ir_valid && n < max) begin
            tick();
            n++;
        end
        if (!ir_valid) n = -1;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1; start_pc = 11'h010; ir_ready = 1'b0;
        tick(); tick();
        checks++;
        if ({ram_rd_en, ir_valid, halted} !== 3'b000 || ram_addr !== 11'h000 || ir !== 32'h0 || pc !== 11'h000) begin
            failures++;
            $display("FAIL reset_state rd_en=%b vld=%b hlt=%b addr=%h ir=%h pc=%h exp 0/0/0/000/0/000",
                     ram_rd_en, ir_valid, halted, ram_addr, ir, pc);
        end
        rst = 1'b0;
        checks++;
        if (ram_rd_en !== 1'b0 || ram_addr !== 11'h000 || ir_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_cycle rd_en=%b addr=%h vld=%b exp 0/000/0", ram_rd_en, ram_addr, ir_valid);
        end
        tick();
        checks++;
        if (ram_rd_en !== 1'b1 || ram_addr !== 11'h010) begin
            failures++;
            $display("FAIL first_issue rd_en=%b addr=%h exp 1/010", ram_rd_en, ram_addr);
        end
        wait_hold(20, n);
        checks++;
        if (n !== RD_LAT + 1) begin
            failures++;
            $display("FAIL fetch_latency got=%0d exp=%0d", n, RD_LAT + 1);
        end
        checks++;
        if (ir !== 32'hE3A0_1005 || pc !== 11'h010 || pc_next !== 11'h011) begin
            failures++;
            $display("FAIL first_ir ir=%h pc=%h pc_next=%h exp e3a01005/010/011", ir, pc, pc_next);
        end
    endtask

    task automatic test_stall();
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (ir_valid !== 1'b1 || ir !== 32'hE3A0_1005 || pc !== 11'h010 || ram_rd_en !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d vld=%b ir=%h pc=%h rd_en=%b exp 1/e3a01005/010/0",
                         c, ir_valid, ir, pc, ram_rd_en);
            end
        end
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        checks++;
        if (ir_valid !== 1'b0 || ram_rd_en !== 1'b1 || ram_addr !== 11'h011) begin
            failures++;
            $display("FAIL accept_next vld=%b rd_en=%b addr=%h exp 0/1/011", ir_valid, ram_rd_en, ram_addr);
        end
    endtask

    task automatic test_branch_wait();
        int n;
        tick();
        branch_en = 1'b1; branch_target = 11'h200;
        tick();
        branch_en = 1'b0;
        checks++;
        if (ram_rd_en !== 1'b1 || ram_addr !== 11'h200 || ir !== 32'hE3A0_1005 || pc !== 11'h010) begin
            failures++;
            $display("FAIL branch_wait_issue rd_en=%b addr=%h ir=%h pc=%h exp 1/200/e3a01005/010",
                     ram_rd_en, ram_addr, ir, pc);
        end
        wait_hold(20, n);
        checks++;
        if (n !== RD_LAT + 1 || ir !== 32'hC0DE_0200 || pc !== 11'h200) begin
            failures++;
            $display("FAIL branch_wait_ir n=%0d ir=%h pc=%h exp 3/c0de0200/200", n, ir, pc);
        end
    endtask

    task automatic test_branch_issue();
        int n;
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        checks++;
        if (ram_rd_en !== 1'b1 || ram_addr !== 11'h201) begin
            failures++;
            $display("FAIL seq_issue rd_en=%b addr=%h exp 1/201", ram_rd_en, ram_addr);
        end
        branch_en = 1'b1; branch_target = 11'h300;
        tick();
        branch_en = 1'b0;
        checks++;
        if (ram_rd_en !== 1'b1 || ram_addr !== 11'h300) begin
            failures++;
            $display("FAIL branch_issue_repeat rd_en=%b addr=%h exp 1/300", ram_rd_en, ram_addr);
        end
        wait_hold(20, n);
        checks++;
        if (n !== RD_LAT + 1 || ir !== 32'hC0DE_0300 || pc !== 11'h300) begin
            failures++;
            $display("FAIL branch_issue_ir n=%0d ir=%h pc=%h exp 3/c0de0300/300", n, ir, pc);
        end
    endtask

    task automatic test_branch_priority();
        int n;
        ir_ready = 1'b1; halt = 1'b1; branch_en = 1'b1; branch_target = 11'h050;
        tick();
        ir_ready = 1'b0; halt = 1'b0; branch_en = 1'b0;
        checks++;
        if (halted !== 1'b0 || ram_rd_en !== 1'b1 || ram_addr !== 11'h050) begin
            failures++;
            $display("FAIL branch_over_halt hlt=%b rd_en=%b addr=%h exp 0/1/050", halted, ram_rd_en, ram_addr);
        end
        wait_hold(20, n);
        checks++;
        if (n !== RD_LAT + 1 || ir !== 32'hC0DE_0050 || pc !== 11'h050 || halted !== 1'b0) begin
            failures++;
            $display("FAIL branch_prio_ir n=%0d ir=%h pc=%h hlt=%b exp 3/c0de0050/050/0", n, ir, pc, halted);
        end
    endtask

    task automatic test_back_to_back_wrap();
        int n;
        rst = 1'b1; start_pc = 11'h7FF;
        tick();
        rst = 1'b0;
        tick();
        wait_hold(20, n);
        checks++;
        if (n !== RD_LAT + 1 || pc !== 11'h7FF || pc_next !== 11'h000 || ir !== 32'hC0DE_07FF) begin
            failures++;
            $display("FAIL wrap_top n=%0d pc=%h pc_next=%h ir=%h exp 3/7ff/000/c0de07ff", n, pc, pc_next, ir);
        end
        ir_ready = 1'b1;
        tick();
        checks++;
        if (ram_rd_en !== 1'b1 || ram_addr !== 11'h000) begin
            failures++;
            $display("FAIL wrap_issue rd_en=%b addr=%h exp 1/000", ram_rd_en, ram_addr);
        end
        wait_hold(20, n);
        ir_ready = 1'b0;
        checks++;
        if (n + 1 !== RD_LAT + 2 || pc !== 11'h000 || pc_next !== 11'h001 || ir !== 32'hC0DE_0000) begin
            failures++;
            $display("FAIL consume_to_valid cyc=%0d pc=%h pc_next=%h ir=%h exp 4/000/001/c0de0000",
                     n + 1, pc, pc_next, ir);
        end
    endtask

    task automatic test_halt();
        halt = 1'b1; ir_ready = 1'b1;
        tick();
        halt = 1'b0; ir_ready = 1'b0;
        checks++;
        if (halted !== 1'b1 || ir_valid !== 1'b0 || ram_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL halt_enter hlt=%b vld=%b rd_en=%b exp 1/0/0", halted, ir_valid, ram_rd_en);
        end
        branch_en = 1'b1; branch_target = 11'h100; ir_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (halted !== 1'b1 || ram_rd_en !== 1'b0 || ir_valid !== 1'b0) begin
                failures++;
                $display("FAIL halt_sticky cyc=%0d hlt=%b rd_en=%b vld=%b exp 1/0/0", c, halted, ram_rd_en, ir_valid);
            end
        end
        branch_en = 1'b0; ir_ready = 1'b0;
    endtask

    task automatic test_reset_inflight();
        int n;
        rst = 1'b1; start_pc = 11'h020;
        tick();
        rst = 1'b0;
        checks++;
        if (halted !== 1'b0) begin
            failures++;
            $display("FAIL halt_cleared hlt=%b exp 0", halted);
        end
        tick();
        tick();
        rst = 1'b1; start_pc = 11'h030;
        tick();
        checks++;
        if (ir !== 32'h0 || pc !== 11'h000 || ir_valid !== 1'b0 || ram_rd_en !== 1'b0 || ram_addr !== 11'h000) begin
            failures++;
            $display("FAIL midflight_reset ir=%h pc=%h vld=%b rd_en=%b addr=%h exp 0/000/0/0/000",
                     ir, pc, ir_valid, ram_rd_en, ram_addr);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (ram_rd_en !== 1'b1 || ram_addr !== 11'h030 || ir !== 32'h0) begin
            failures++;
            $display("FAIL restart_issue rd_en=%b addr=%h ir=%h exp 1/030/0", ram_rd_en, ram_addr, ir);
        end
        wait_hold(20, n);
        checks++;
        if (n !== RD_LAT + 1 || ir !== 32'hC0DE_0030 || pc !== 11'h030) begin
            failures++;
            $display("FAIL restart_ir n=%0d ir=%h pc=%h exp 3/c0de0030/030", n, ir, pc);
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_branch_wait();
        test_branch_issue();
        test_branch_priority();
        test_back_to_back_wrap();
        test_halt();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
